sobel_edge_detect_8bits: RTL

SOBEL_EDGE_DETECT_8BITS -- requirements
Module: sobel_edge_detect_8bits

---
 rtl/sobel_edge_detect_8bits_if.sv | 41 ++++
 rtl/sobel_edge_detect_8bits.sv | 126 ++++++++++++
 2 files changed

// File: rtl/sobel_edge_detect_8bits_if.sv
// Video window stream into, and edge stream out of, sobel_edge_detect_8bits.
// The master modport is the pixel source and sink; the slave modport is the detector.
interface sobel_edge_detect_8bits_if;
  logic       pre_video_vsync;
  logic       pre_video_hsync;
  logic       pre_video_de;
  logic [9:0] pre_video_xpos;
  logic [9:0] pre_video_ypos;
  logic [7:0] pre_matrix_p11, pre_matrix_p12, pre_matrix_p13;
  logic [7:0] pre_matrix_p21, pre_matrix_p22, pre_matrix_p23;
  logic [7:0] pre_matrix_p31, pre_matrix_p32, pre_matrix_p33;
  logic [7:0] threshold;

  logic       post_video_vsync;
  logic       post_video_hsync;
  logic       post_video_de;
  logic [9:0] post_video_xpos;
  logic [9:0] post_video_ypos;
  logic [7:0] post_edge_mag;
  logic       post_edge_bit;

  modport master (
    output pre_video_vsync, pre_video_hsync, pre_video_de, pre_video_xpos, pre_video_ypos,
    output pre_matrix_p11, pre_matrix_p12, pre_matrix_p13,
    output pre_matrix_p21, pre_matrix_p22, pre_matrix_p23,
    output pre_matrix_p31, pre_matrix_p32, pre_matrix_p33,
    output threshold,
    input  post_video_vsync, post_video_hsync, post_video_de, post_video_xpos, post_video_ypos,
    input  post_edge_mag, post_edge_bit
  );

  modport slave (
    input  pre_video_vsync, pre_video_hsync, pre_video_de, pre_video_xpos, pre_video_ypos,
    input  pre_matrix_p11, pre_matrix_p12, pre_matrix_p13,
    input  pre_matrix_p21, pre_matrix_p22, pre_matrix_p23,
    input  pre_matrix_p31, pre_matrix_p32, pre_matrix_p33,
    input  threshold,
    output post_video_vsync, post_video_hsync, post_video_de, post_video_xpos, post_video_ypos,
    output post_edge_mag, post_edge_bit
  );
endinterface

// File: rtl/sobel_edge_detect_8bits.sv
// 3-stage Sobel |Gx|+|Gy| edge detector on a 3x3 window stream, threshold latched per frame.
// Define SOBEL_BORDER_MASK_EN to force mag/bit to 0 on border and out-of-frame pixels.
module sobel_edge_detect_8bits #(
  parameter int unsigned IMG_WIDTH         = 640,
  parameter int unsigned IMG_HEIGHT        = 480,
  parameter logic [7:0]  DEFAULT_THRESHOLD = 8'd64
) (
  input logic                      video_pclk,
  input logic                      sys_rst_n,
  sobel_edge_detect_8bits_if.slave vid
);

  if (IMG_WIDTH < 3 || IMG_WIDTH > 1024 || IMG_HEIGHT < 3 || IMG_HEIGHT > 1024) begin : g_geom_chk
    $error("sobel_edge_detect_8bits: image geometry does not fit 10-bit positions");
  end

  // Stage 1: directional tap sums, stage 2: absolute gradients, stage 3: magnitude sum.
  logic [9:0]  gx_p_d, gx_p_q, gx_n_d, gx_n_q, gy_p_d, gy_p_q, gy_n_d, gy_n_q;
  logic [9:0]  abs_gx_d, abs_gx_q, abs_gy_d, abs_gy_q;
  logic [10:0] sum_d, sum_q;
  logic [7:0]  thr_d, thr_q;

  logic [2:0]       vs_d, vs_q, hs_d, hs_q, de_d, de_q;
  logic [2:0][9:0]  xpos_d, xpos_q, ypos_d, ypos_q;

`ifdef SOBEL_BORDER_MASK_EN
  logic [2:0] mask_d, mask_q;
  logic       border;

  always_comb begin
    border = (vid.pre_video_xpos < 10'd2) || (vid.pre_video_ypos < 10'd2) ||
             ({22'd0, vid.pre_video_xpos} > (IMG_WIDTH - 1)) ||
             ({22'd0, vid.pre_video_ypos} > (IMG_HEIGHT - 1));
    mask_d = {mask_q[1:0], border};
  end

  always_ff @(posedge video_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end
`endif

  always_comb begin
    gx_p_d = {2'b00, vid.pre_matrix_p13} + {1'b0, vid.pre_matrix_p23, 1'b0} +
             {2'b00, vid.pre_matrix_p33};
    gx_n_d = {2'b00, vid.pre_matrix_p11} + {1'b0, vid.pre_matrix_p21, 1'b0} +
             {2'b00, vid.pre_matrix_p31};
    gy_p_d = {2'b00, vid.pre_matrix_p31} + {1'b0, vid.pre_matrix_p32, 1'b0} +
             {2'b00, vid.pre_matrix_p33};
    gy_n_d = {2'b00, vid.pre_matrix_p11} + {1'b0, vid.pre_matrix_p12, 1'b0} +
             {2'b00, vid.pre_matrix_p13};

    // Subtract the smaller from the larger so no signed intermediate is needed.
    abs_gx_d = (gx_p_q >= gx_n_q) ? (gx_p_q - gx_n_q) : (gx_n_q - gx_p_q);
    abs_gy_d = (gy_p_q >= gy_n_q) ? (gy_p_q - gy_n_q) : (gy_n_q - gy_p_q);
    sum_d    = {1'b0, abs_gx_q} + {1'b0, abs_gy_q};

    vs_d   = {vs_q[1:0], vid.pre_video_vsync};
    hs_d   = {hs_q[1:0], vid.pre_video_hsync};
    de_d   = {de_q[1:0], vid.pre_video_de};
    xpos_d = {xpos_q[1:0], vid.pre_video_xpos};
    ypos_d = {ypos_q[1:0], vid.pre_video_ypos};

    // vs_q[0] doubles as the previous-vsync sample of the frame-start edge detector.
    thr_d = thr_q;
    if (vid.pre_video_vsync && !vs_q[0]) begin
      thr_d = vid.threshold;
    end
  end

  always_ff @(posedge video_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gx_p_q   <= '0;
      gx_n_q   <= '0;
      gy_p_q   <= '0;
      gy_n_q   <= '0;
      abs_gx_q <= '0;
      abs_gy_q <= '0;
      sum_q    <= '0;
      thr_q    <= DEFAULT_THRESHOLD;
      vs_q     <= '0;
      hs_q     <= '0;
      de_q     <= '0;
      xpos_q   <= '0;
      ypos_q   <= '0;
    end else begin
      gx_p_q   <= gx_p_d;
      gx_n_q   <= gx_n_d;
      gy_p_q   <= gy_p_d;
      gy_n_q   <= gy_n_d;
      abs_gx_q <= abs_gx_d;
      abs_gy_q <= abs_gy_d;
      sum_q    <= sum_d;
      thr_q    <= thr_d;
      vs_q     <= vs_d;
      hs_q     <= hs_d;
      de_q     <= de_d;
      xpos_q   <= xpos_d;
      ypos_q   <= ypos_d;
    end
  end

  logic       pass;
  logic [7:0] mag_sat;

  always_comb begin
`ifdef SOBEL_BORDER_MASK_EN
    pass = de_q[2] && !mask_q[2];
`else
    pass = de_q[2];
`endif
    mag_sat = (sum_q > 11'd255) ? 8'hff : sum_q[7:0];

    vid.post_video_vsync = vs_q[2];
    vid.post_video_hsync = hs_q[2];
    vid.post_video_de    = de_q[2];
    vid.post_video_xpos  = xpos_q[2];
    vid.post_video_ypos  = ypos_q[2];
    vid.post_edge_mag    = pass ? mag_sat : 8'd0;
    vid.post_edge_bit    = pass && (sum_q > {3'b000, thr_q});
  end

endmodule
